// File: rtl/dphy_32b_demap.sv
// rtl/dphy_32b_demap.sv - 32-bit packet word to D-PHY lane byte demapper
//
// Purpose: accepts 32-bit packet words (byte [7:0] earliest) and spreads the
// byte stream across DATA_LANES byte lanes, stream byte k going to lane
// (k mod DATA_LANES). An 8-byte in-order buffer decouples the input word rate
// from the output beat rate.
//
// Ports:
//   byte_clk_i    - byte clock, the only clock
//   rst_n_i       - asynchronous active-low reset
//   word_data_i   - input packet word, bits [7:0] are the earliest byte
//   valid_i       - word_data_i valid
//   ready_o       - block can accept a word this cycle
//   last_i        - current word is the final word of the packet
//   last_bytes_i  - valid bytes in the last word (0 means 4)
//   lane_data_o   - lane i byte on bits [8*i+7:8*i]
//   lane_valid_o  - per-lane byte valid
//   eop_o         - current beat is the final beat of the packet
//   ready_i       - downstream accepts the current beat

module dphy_32b_demap #(
  parameter int DATA_LANES = 4
) (
  input  logic                      byte_clk_i,
  input  logic                      rst_n_i,
  input  logic [31:0]               word_data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      last_i,
  input  logic [1:0]                last_bytes_i,
  output logic [DATA_LANES*8-1:0]   lane_data_o,
  output logic [DATA_LANES-1:0]     lane_valid_o,
  output logic                      eop_o,
  input  logic                      ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam bit         SUPPORTED = (DATA_LANES >= 1) && (DATA_LANES <= 4);
  localparam logic [3:0] LANES     = 4'(DATA_LANES);

  state_t     state_q, state_d;
  logic [7:0] buf_q [8];
  logic [7:0] buf_d [8];
  logic [3:0] count_q, count_d;

  logic       beat;
  logic       in_xfer;
  logic       out_xfer;
  logic [3:0] nvalid;
  logic [3:0] push_n;
  logic [3:0] pop_n;
  logic [3:0] base;

  // Everything below is decoded from registered state, so the presented beat
  // cannot change while ready_i is low: in DATA a push only appends behind the
  // bytes on the lanes, and no push is possible in FLUSH.
  assign ready_o  = SUPPORTED && (state_q != FLUSH) && (count_q <= 4'd4);
  assign beat     = SUPPORTED &&
                    ((count_q >= LANES) || ((state_q == FLUSH) && (count_q != 4'd0)));
  assign nvalid   = !beat ? 4'd0 : ((count_q >= LANES) ? LANES : count_q);
  assign eop_o    = beat && (state_q == FLUSH) && (count_q <= LANES);
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = beat && ready_i;
  assign pop_n    = out_xfer ? nvalid : 4'd0;

  always_comb begin
    push_n = 4'd0;
    if (in_xfer) begin
      if (last_i && (last_bytes_i != 2'd0)) push_n = {2'b00, last_bytes_i};
      else                                  push_n = 4'd4;
    end
  end

  // Lane outputs: the oldest min(count, DATA_LANES) bytes; unused lanes zero.
  always_comb begin
    lane_data_o  = '0;
    lane_valid_o = '0;
    for (int i = 0; i < DATA_LANES; i++) begin
      if (4'(i) < nvalid) begin
        lane_valid_o[i]        = 1'b1;
        lane_data_o[i*8 +: 8]  = buf_q[3'(i)];
      end
    end
  end

  // Buffer update: shift out the popped bytes, then append the pushed bytes
  // right behind what remains. The ready_o limit of count <= 4 guarantees the
  // appended bytes always fit in the 8 entries.
  always_comb begin
    base = count_q - pop_n;
    for (int j = 0; j < 8; j++) begin
      if ((4'(j) + pop_n) < count_q) buf_d[j] = buf_q[3'(j + int'(pop_n))];
      else                           buf_d[j] = 8'h00;
    end
    for (int k = 0; k < 4; k++) begin
      if (4'(k) < push_n) buf_d[3'(base + 4'(k))] = word_data_i[k*8 +: 8];
    end
  end

  assign count_d = count_q + push_n - pop_n;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_xfer) state_d = last_i ? FLUSH : DATA;
      DATA:    if (in_xfer && last_i) state_d = FLUSH;
      FLUSH:   if (out_xfer && eop_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      for (int j = 0; j < 8; j++) buf_q[j] <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int j = 0; j < 8; j++) buf_q[j] <= buf_d[j];
    end
  end

endmodule
